fetch_redirect_ctrl: RTL and testbench
======================================

FETCH_REDIRECT_CTRL -- requirements
Module: fetch_redirect_ctrl

Interface
REQ-001 SHALL have port clk, input, 1: sole clock; all state updates on its rising edge.
REQ-002 SHALL have port rst, input, 1: asynchronous, active-low reset (0 = reset asserted), acting immediately regardless of clk.
REQ-003 SHALL have port id_valid, input, 1: the ID-stage instruction is real (not a bubble).
REQ-004 SHALL have ports is_beq, is_bne, is_j, is_jr, input, 1 each: ID-stage decode flags; is_j covers j and jal.
REQ-005 SHALL have ports cmp_a and cmp_b, input, 32 each: forwarded branch compare operands.
REQ-006 SHALL have port imm16, input, 16: branch immediate.
REQ-007 SHALL have port target26, input, 26: jump index field.
REQ-008 SHALL have port id_pc_plus4, input, 32: address of the ID instruction plus 4.
REQ-009 SHALL have port rs_val, input, 32: forwarded rs value, the jr target.
REQ-010 SHALL have port load_use, input, 1: load-use hazard detected on the ID instruction.
REQ-011 SHALL have port imem_ready, input, 1: instruction memory accepts a fetch this cycle.
REQ-012 SHALL have port holdPC, output, 1: freezes the PC register.
REQ-013 SHALL have port isBranch, output, 1: PC loads PC + PCoffset.
REQ-014 SHALL have port PCsrc, output, 1: PC loads jVal.
REQ-015 SHALL have port PCoffset, output, 32: branch offset.
REQ-016 SHALL have port jVal, output, 32: absolute jump target.
REQ-017 SHALL have port flush_if, output, 1: squashes the IF/ID register.
REQ-018 SHALL have port hold_ifid, output, 1: freezes the IF/ID register.
REQ-019 SHALL have port redirect_cnt, output, 16: count of applied redirects.

Function
REQ-020 SHALL implement the FSM states RUN, LU_STALL and PEND.
REQ-021 SHALL compute, combinationally from the ID inputs, redirect request = id_valid & (is_jr | is_j | (is_beq & cmp_a==cmp_b) | (is_bne & cmp_a!=cmp_b)), resolving multiple asserted flags by priority is_jr > is_j > is_beq > is_bne.
REQ-022 SHALL form the branch offset as sign_extend(imm16) << 2, the j target as {id_pc_plus4[31:28], target26, 2'b00}, and the jr target as rs_val.
REQ-023 SHALL never assert isBranch and PCsrc in the same cycle.
REQ-024 SHALL drive PCoffset to 0 whenever isBranch=0 and jVal to 0 whenever PCsrc=0.
REQ-025 SHALL, in RUN with load_use=1, assert holdPC and hold_ifid, suppress any redirect, and transition to LU_STALL.
REQ-026 SHALL, in LU_STALL, assert holdPC and hold_ifid for exactly one cycle, ignore all ID inputs, and return to RUN.
REQ-027 SHALL, in RUN with load_use=0, imem_ready=1 and a redirect request, in that same cycle pulse isBranch (branch) or PCsrc (j/jr) with its operand, assert flush_if, keep holdPC=0, and increment redirect_cnt.
REQ-028 SHALL, in RUN with load_use=0 and imem_ready=0, assert holdPC and hold_ifid; if a redirect request is also present, latch its kind (branch/jump), PCoffset and jVal into internal registers and transition to PEND.
REQ-029 SHALL, in PEND, ignore all ID inputs and assert holdPC and hold_ifid while imem_ready=0.
REQ-030 SHALL, in PEND on the first cycle with imem_ready=1, emit the latched redirect for exactly one cycle, assert flush_if, increment redirect_cnt, and return to RUN.
REQ-031 SHALL, in RUN with no hazard, imem_ready=1 and no redirect request, drive all control outputs to 0.
REQ-032 SHALL make redirect_cnt saturate at 16'hFFFF.

Reset
REQ-033 SHALL, while rst=0, force state=RUN, clear the pending-redirect registers, and drive every output (including redirect_cnt) to 0.
REQ-034 SHALL discard any latched redirect when reset is asserted during PEND, with no redirect emitted after reset release.

Verification
REQ-035 SHALL cover: beq with cmp_a=cmp_b=5, imm16=16'hFFFC, imem_ready=1 -> same cycle isBranch=1, PCoffset=32'hFFFFFFF0, flush_if=1, redirect_cnt=1.
REQ-036 SHALL cover: j with id_pc_plus4=32'hA0000010, target26=26'h0000040 -> PCsrc=1, jVal=32'hA0000100.
REQ-037 SHALL cover: bne with load_use=1 -> holdPC=hold_ifid=1 for 2 cycles, no redirect; equal operands afterwards -> no redirect.
REQ-038 SHALL cover: jr with rs_val=32'h400 while imem_ready=0 for 3 cycles -> holdPC=1 for 3 cycles, then PCsrc=1, jVal=32'h400, flush_if=1 on the ready cycle.
REQ-039 SHALL cover: rst=0 asserted mid-PEND, then released with imem_ready=1 -> no PCsrc/isBranch pulse, redirect_cnt=0.
REQ-040 SHALL cover: redirect_cnt preloaded via 65535 redirects, then one more -> count stays 16'hFFFF.

Source files
------------

// File: rtl/fetch_redirect_ctrl.sv
// Fetch redirect control: resolves ID-stage branches/jumps, coordinates PC and IF/ID
// holds with load-use stalls and instruction-memory back-pressure, and counts redirects.
module fetch_redirect_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic        id_valid,
  input  logic        is_beq,
  input  logic        is_bne,
  input  logic        is_j,
  input  logic        is_jr,
  input  logic [31:0] cmp_a,
  input  logic [31:0] cmp_b,
  input  logic [15:0] imm16,
  input  logic [25:0] target26,
  input  logic [31:0] id_pc_plus4,
  input  logic [31:0] rs_val,
  input  logic        load_use,
  input  logic        imem_ready,
  output logic        holdPC,
  output logic        isBranch,
  output logic        PCsrc,
  output logic [31:0] PCoffset,
  output logic [31:0] jVal,
  output logic        flush_if,
  output logic        hold_ifid,
  output logic [15:0] redirect_cnt
);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    LU_STALL = 2'd1,
    PEND     = 2'd2
  } state_t;

  state_t      state_r, state_nxt_s;
  logic        pend_jump_r;
  logic [31:0] pend_off_r;
  logic [31:0] pend_jval_r;
  logic        latch_s;
  logic        inc_s;
  logic        req_jump_s;
  logic        req_br_s;
  logic        cmp_eq_s;
  logic [31:0] br_off_s;
  logic [31:0] jmp_tgt_s;

  // Decode the ID-stage redirect request; the highest-priority asserted flag alone decides
  // the kind, and its condition alone decides whether the redirect is taken.
  always_comb begin
    cmp_eq_s   = (cmp_a == cmp_b);
    br_off_s   = {{14{imm16[15]}}, imm16, 2'b00};
    jmp_tgt_s  = is_jr ? rs_val : {id_pc_plus4[31:28], target26, 2'b00};
    req_jump_s = id_valid & (is_jr | is_j);
    if (is_jr || is_j) begin
      req_br_s = 1'b0;
    end else if (is_beq) begin
      req_br_s = id_valid & cmp_eq_s;
    end else begin
      req_br_s = id_valid & is_bne & ~cmp_eq_s;
    end
  end

  // Next-state and control outputs; reset overrides everything so outputs read 0 while held.
  always_comb begin
    state_nxt_s = state_r;
    holdPC      = 1'b0;
    hold_ifid   = 1'b0;
    isBranch    = 1'b0;
    PCsrc       = 1'b0;
    PCoffset    = 32'd0;
    jVal        = 32'd0;
    flush_if    = 1'b0;
    latch_s     = 1'b0;
    inc_s       = 1'b0;
    case (state_r)
      RUN: begin
        if (load_use) begin
          holdPC      = 1'b1;
          hold_ifid   = 1'b1;
          state_nxt_s = LU_STALL;
        end else if (!imem_ready) begin
          holdPC    = 1'b1;
          hold_ifid = 1'b1;
          if (req_jump_s || req_br_s) begin
            latch_s     = 1'b1;
            state_nxt_s = PEND;
          end else begin
            state_nxt_s = RUN;
          end
        end else if (req_jump_s) begin
          PCsrc    = 1'b1;
          jVal     = jmp_tgt_s;
          flush_if = 1'b1;
          inc_s    = 1'b1;
        end else if (req_br_s) begin
          isBranch = 1'b1;
          PCoffset = br_off_s;
          flush_if = 1'b1;
          inc_s    = 1'b1;
        end else begin
          state_nxt_s = RUN;
        end
      end
      LU_STALL: begin
        holdPC      = 1'b1;
        hold_ifid   = 1'b1;
        state_nxt_s = RUN;
      end
      PEND: begin
        if (!imem_ready) begin
          holdPC    = 1'b1;
          hold_ifid = 1'b1;
        end else begin
          if (pend_jump_r) begin
            PCsrc = 1'b1;
            jVal  = pend_jval_r;
          end else begin
            isBranch = 1'b1;
            PCoffset = pend_off_r;
          end
          flush_if    = 1'b1;
          inc_s       = 1'b1;
          state_nxt_s = RUN;
        end
      end
      default: begin
        state_nxt_s = RUN;
      end
    endcase
    if (!rst) begin
      state_nxt_s = RUN;
      holdPC      = 1'b0;
      hold_ifid   = 1'b0;
      isBranch    = 1'b0;
      PCsrc       = 1'b0;
      PCoffset    = 32'd0;
      jVal        = 32'd0;
      flush_if    = 1'b0;
      latch_s     = 1'b0;
      inc_s       = 1'b0;
    end else begin
      state_nxt_s = state_nxt_s;
    end
  end

  // State register, pending-redirect capture and saturating redirect counter.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r      <= RUN;
      pend_jump_r  <= 1'b0;
      pend_off_r   <= 32'd0;
      pend_jval_r  <= 32'd0;
      redirect_cnt <= 16'd0;
    end else begin
      state_r <= state_nxt_s;
      if (latch_s) begin
        pend_jump_r <= req_jump_s;
        pend_off_r  <= req_jump_s ? 32'd0 : br_off_s;
        pend_jval_r <= req_jump_s ? jmp_tgt_s : 32'd0;
      end
      if (inc_s && (redirect_cnt != 16'hFFFF)) begin
        redirect_cnt <= redirect_cnt + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_fetch_redirect_ctrl.sv
// Directed bench for fetch_redirect_ctrl: inputs change on the falling edge and
// outputs are checked 1ns later, well away from the rising edge.
module tb_fetch_redirect_ctrl;
  logic        clk = 1'b0;
  logic        rst;
  logic        id_valid, is_beq, is_bne, is_j, is_jr;
  logic [31:0] cmp_a, cmp_b, id_pc_plus4, rs_val;
  logic [15:0] imm16;
  logic [25:0] target26;
  logic        load_use, imem_ready;
  logic        holdPC, isBranch, PCsrc, flush_if, hold_ifid;
  logic [31:0] PCoffset, jVal;
  logic [15:0] redirect_cnt;

  int vecs = 0;
  int errs = 0;

  always #5 clk = ~clk;

  fetch_redirect_ctrl dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .is_beq(is_beq), .is_bne(is_bne),
    .is_j(is_j), .is_jr(is_jr), .cmp_a(cmp_a), .cmp_b(cmp_b), .imm16(imm16),
    .target26(target26), .id_pc_plus4(id_pc_plus4), .rs_val(rs_val),
    .load_use(load_use), .imem_ready(imem_ready), .holdPC(holdPC), .isBranch(isBranch),
    .PCsrc(PCsrc), .PCoffset(PCoffset), .jVal(jVal), .flush_if(flush_if),
    .hold_ifid(hold_ifid), .redirect_cnt(redirect_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // ctl bits: {holdPC, isBranch, PCsrc, flush_if, hold_ifid}
  task automatic chk_ctl(input string tag, input logic [4:0] exp);
    chk(tag, {27'd0, holdPC, isBranch, PCsrc, flush_if, hold_ifid}, {27'd0, exp});
  endtask

  task automatic bubble();
    id_valid = 1'b0; is_beq = 1'b0; is_bne = 1'b0; is_j = 1'b0; is_jr = 1'b0;
    cmp_a = 32'd0; cmp_b = 32'd0; imm16 = 16'd0; target26 = 26'd0;
    id_pc_plus4 = 32'd0; rs_val = 32'd0; load_use = 1'b0; imem_ready = 1'b1;
  endtask

  task automatic next();
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b0;
    bubble();
    #1;
    chk_ctl("reset_ctl", 5'b00000);
    chk("reset_cnt", {16'd0, redirect_cnt}, 32'd0);
    chk("reset_jval", jVal, 32'd0);
    next();
    rst = 1'b1;

    // beq taken, negative offset
    id_valid = 1'b1; is_beq = 1'b1; cmp_a = 32'd5; cmp_b = 32'd5; imm16 = 16'hFFFC;
    #1;
    chk_ctl("beq_ctl", 5'b01010);
    chk("beq_off", PCoffset, 32'hFFFFFFF0);
    chk("beq_jval0", jVal, 32'd0);
    next(); bubble();
    #1;
    chk("beq_cnt", {16'd0, redirect_cnt}, 32'd1);
    chk_ctl("beq_after", 5'b00000);

    // j target formation
    id_valid = 1'b1; is_j = 1'b1; id_pc_plus4 = 32'hA0000010; target26 = 26'h0000040;
    #1;
    chk_ctl("j_ctl", 5'b00110);
    chk("j_jval", jVal, 32'hA0000100);
    chk("j_off0", PCoffset, 32'd0);
    next(); bubble();

    // jr wins over j and beq
    id_valid = 1'b1; is_jr = 1'b1; is_j = 1'b1; is_beq = 1'b1; rs_val = 32'h00001234;
    target26 = 26'h3FFFFFF;
    #1;
    chk_ctl("prio_ctl", 5'b00110);
    chk("prio_jval", jVal, 32'h00001234);
    next(); bubble();
    #1;
    chk("prio_cnt", {16'd0, redirect_cnt}, 32'd3);

    // invalid ID instruction, and bne with equal operands: no redirect
    is_j = 1'b1; target26 = 26'h1;
    #1;
    chk_ctl("bubble_j", 5'b00000);
    next(); bubble();
    id_valid = 1'b1; is_bne = 1'b1; cmp_a = 32'd7; cmp_b = 32'd7; imm16 = 16'h0004;
    #1;
    chk_ctl("bne_eq", 5'b00000);
    chk("bne_eq_off", PCoffset, 32'd0);

    // taken bne under load-use: two hold cycles, no redirect
    next();
    cmp_b = 32'd8; load_use = 1'b1;
    #1;
    chk_ctl("lu_c1", 5'b10001);
    next();
    load_use = 1'b0;
    #1;
    chk_ctl("lu_c2", 5'b10001);
    next();
    cmp_b = 32'd7;
    #1;
    chk_ctl("lu_after_eq", 5'b00000);
    next(); bubble();
    #1;
    chk("lu_cnt", {16'd0, redirect_cnt}, 32'd3);

    // jr stalled by imem for 3 cycles, later ID inputs ignored
    id_valid = 1'b1; is_jr = 1'b1; rs_val = 32'h00000400; imem_ready = 1'b0;
    #1;
    chk_ctl("pend_c1", 5'b10001);
    next();
    rs_val = 32'hDEADBEEF; is_jr = 1'b0; is_beq = 1'b1; cmp_a = 32'd1; cmp_b = 32'd1;
    #1;
    chk_ctl("pend_c2", 5'b10001);
    next();
    #1;
    chk_ctl("pend_c3", 5'b10001);
    next(); bubble();
    #1;
    chk_ctl("pend_fire", 5'b00110);
    chk("pend_jval", jVal, 32'h00000400);
    next();
    #1;
    chk_ctl("pend_done", 5'b00000);
    chk("pend_cnt", {16'd0, redirect_cnt}, 32'd4);

    // pending branch with positive offset
    id_valid = 1'b1; is_beq = 1'b1; cmp_a = 32'd9; cmp_b = 32'd9; imm16 = 16'h0010;
    imem_ready = 1'b0;
    #1;
    chk_ctl("pbr_hold", 5'b10001);
    next(); bubble();
    #1;
    chk_ctl("pbr_fire", 5'b01010);
    chk("pbr_off", PCoffset, 32'h00000040);
    next();
    #1;
    chk("pbr_cnt", {16'd0, redirect_cnt}, 32'd5);

    // reset during PEND discards the latched jump
    id_valid = 1'b1; is_jr = 1'b1; rs_val = 32'h00000800; imem_ready = 1'b0;
    next(); bubble(); imem_ready = 1'b0;
    #1;
    chk_ctl("rpend_hold", 5'b10001);
    #2;
    rst = 1'b0;
    #1;
    chk_ctl("rpend_rst_ctl", 5'b00000);
    chk("rpend_rst_cnt", {16'd0, redirect_cnt}, 32'd0);
    next();
    rst = 1'b1; imem_ready = 1'b1;
    #1;
    chk_ctl("rpend_rel", 5'b00000);
    next();
    #1;
    chk_ctl("rpend_rel2", 5'b00000);
    chk("rpend_cnt", {16'd0, redirect_cnt}, 32'd0);

    // counter saturation
    id_valid = 1'b1; is_j = 1'b1; target26 = 26'h10;
    repeat (65534) @(posedge clk);
    next();
    #1;
    chk("sat_fffe", {16'd0, redirect_cnt}, 32'h0000FFFE);
    next();
    #1;
    chk("sat_ffff", {16'd0, redirect_cnt}, 32'h0000FFFF);
    chk_ctl("sat_ctl", 5'b00110);
    next();
    #1;
    chk("sat_hold", {16'd0, redirect_cnt}, 32'h0000FFFF);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
